// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and long-latency scoreboard
// stalls, and a branch-wait/flush FSM, with a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned MAX_LONG   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [4:0]              id_rd,
  input  logic                    id_write_reg,
  input  logic                    id_is_long,
  input  logic                    id_is_branch,
  input  logic [FWD_STAGES-1:0]   stage_write_reg,
  input  logic [5*FWD_STAGES-1:0] stage_rd,
  input  logic [FWD_STAGES-1:0]   stage_not_ready,
  input  logic                    br_resolve,
  input  logic                    br_taken,
  input  logic                    long_done,
  input  logic [4:0]              long_done_rd,
  input  logic                    imem_wait,
  input  logic                    dmem_wait,
  output logic                    pipe_enable,
  output logic                    if_pc_write_enable,
  output logic                    ifid_write_enable,
  output logic                    id_bubble,
  output logic                    id_flush,
  output logic [2:0]              forward_rs1,
  output logic [2:0]              forward_rs2,
  output logic                    long_full,
  output logic                    sb_error,
  output logic [CNT_W-1:0]        stall_count
);

  localparam int unsigned LCW = $clog2(MAX_LONG + 1);

  typedef enum logic [1:0] {BR_IDLE, BR_WAIT, BR_FLUSH} br_state_t;

  br_state_t      br_state, br_next;
  logic [31:0]    busy;
  logic [LCW-1:0] long_cnt;

  logic [3:0] m1, m2;
  logic       haz1, haz2, waw, long_stall, data_stall;
  logic       issue, long_set, done_ok;

  // Lowest-index stage writing rs: {not_ready, stage index}, index 0 when no match.
  function automatic logic [3:0] lookup(input logic [4:0] rs,
                                        input logic [FWD_STAGES-1:0] wr,
                                        input logic [5*FWD_STAGES-1:0] rd,
                                        input logic [FWD_STAGES-1:0] nr);
    logic [3:0] r;
    r = 4'd0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (wr[k-1] && (rd[5*(k-1) +: 5] == rs)) r = {nr[k-1], 3'(k)};
    end
    return r;
  endfunction

  always_comb begin
    m1          = lookup(id_rs1, stage_write_reg, stage_rd, stage_not_ready);
    m2          = lookup(id_rs2, stage_write_reg, stage_rd, stage_not_ready);
    pipe_enable = !(imem_wait || dmem_wait);
    long_full   = (long_cnt == LCW'(MAX_LONG));
    haz1        = id_uses_rs1 && (id_rs1 != 5'd0) && (busy[id_rs1] || m1[3]);
    haz2        = id_uses_rs2 && (id_rs2 != 5'd0) && (busy[id_rs2] || m2[3]);
    waw         = id_write_reg && (id_rd != 5'd0) && busy[id_rd];
    long_stall  = id_is_long && long_full && !long_done;
    data_stall  = id_valid && (haz1 || haz2 || waw || long_stall);
    forward_rs1 = (id_uses_rs1 && (id_rs1 != 5'd0) && !data_stall) ? m1[2:0] : 3'd0;
    forward_rs2 = (id_uses_rs2 && (id_rs2 != 5'd0) && !data_stall) ? m2[2:0] : 3'd0;
    issue       = id_valid && !data_stall && pipe_enable && (br_state == BR_IDLE);
    long_set    = issue && id_is_long && (id_rd != 5'd0);
    done_ok     = long_done && (long_cnt != '0) && busy[long_done_rd];
  end

  always_ff @(posedge clk) begin
    if (reset) br_state <= BR_IDLE;
    else       br_state <= br_next;
  end

  // Branch FSM next state and pipeline control outputs; data stall overrides last.
  always_comb begin
    br_next            = br_state;
    if_pc_write_enable = 1'b1;
    ifid_write_enable  = 1'b1;
    id_bubble          = 1'b0;
    id_flush           = 1'b0;
    case (br_state)
      BR_IDLE: begin
        if (issue && id_is_branch) br_next = BR_WAIT;
      end
      BR_WAIT: begin
        if_pc_write_enable = br_resolve;
        ifid_write_enable  = 1'b0;
        id_bubble          = 1'b1;
        if (pipe_enable && br_resolve) br_next = br_taken ? BR_FLUSH : BR_IDLE;
      end
      BR_FLUSH: begin
        id_flush  = 1'b1;
        id_bubble = 1'b1;
        if (pipe_enable) br_next = BR_IDLE;
      end
      default: br_next = BR_IDLE;
    endcase
    if (data_stall) begin
      if_pc_write_enable = 1'b0;
      ifid_write_enable  = 1'b0;
      id_bubble          = 1'b1;
    end
  end

  // Scoreboard: completions clear even while the pipe is held; a same-rd issue wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      long_cnt    <= '0;
      sb_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      if (done_ok)  busy[long_done_rd] <= 1'b0;
      if (long_set) busy[id_rd]        <= 1'b1;
      long_cnt <= long_cnt + LCW'(long_set) - LCW'(done_ok);
      if (long_done && !done_ok) sb_error <= 1'b1;
      if (id_bubble && pipe_enable && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; stimulus queues expected outputs, a
// negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_write_reg, id_is_long, id_is_branch;
  logic [4:0]    id_rs1, id_rs2, id_rd, long_done_rd;
  logic [FS-1:0] stage_write_reg, stage_not_ready;
  logic [5*FS-1:0] stage_rd;
  logic          br_resolve, br_taken, long_done, imem_wait, dmem_wait;
  logic          pipe_enable, if_pc_write_enable, ifid_write_enable, id_bubble, id_flush;
  logic [2:0]    forward_rs1, forward_rs2;
  logic          long_full, sb_error;
  logic [15:0]   stall_count;

  pipeline_hazard_ctrl #(.FWD_STAGES(FS), .MAX_LONG(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_write_reg(id_write_reg), .id_is_long(id_is_long), .id_is_branch(id_is_branch),
    .stage_write_reg(stage_write_reg), .stage_rd(stage_rd), .stage_not_ready(stage_not_ready),
    .br_resolve(br_resolve), .br_taken(br_taken), .long_done(long_done),
    .long_done_rd(long_done_rd), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .pipe_enable(pipe_enable), .if_pc_write_enable(if_pc_write_enable),
    .ifid_write_enable(ifid_write_enable), .id_bubble(id_bubble), .id_flush(id_flush),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2), .long_full(long_full),
    .sb_error(sb_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  ctl;   // {pipe_enable, pc_we, ifid_we, bubble, flush}
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic        lf;
    logic        sbe;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] NORM  = 5'b11100;
  localparam logic [4:0] STALL = 5'b10010;
  localparam logic [4:0] WRES  = 5'b11010;
  localparam logic [4:0] FLUSH = 5'b11111;

  task automatic clr();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_write_reg = 0;
    id_is_long = 0; id_is_branch = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    stage_write_reg = '0; stage_rd = '0; stage_not_ready = '0;
    br_resolve = 0; br_taken = 0; long_done = 0; long_done_rd = '0;
    imem_wait = 0; dmem_wait = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_o(input string nm, input logic [4:0] ctl, input logic [2:0] f1,
                          input logic [2:0] f2, input logic lf, input logic sbe,
                          input logic [15:0] sc);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.f1 = f1; e.f2 = f2; e.lf = lf; e.sbe = sbe; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic long_issue(input logic [4:0] rd);
    id_valid = 1; id_is_long = 1; id_write_reg = 1; id_rd = rd;
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is queued.
  initial begin
    exp_t e;
    logic [4:0] ctl;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        ctl = {pipe_enable, if_pc_write_enable, ifid_write_enable, id_bubble, id_flush};
        n_cmp++;
        if (ctl !== e.ctl || forward_rs1 !== e.f1 || forward_rs2 !== e.f2 ||
            long_full !== e.lf || sb_error !== e.sbe || stall_count !== e.sc) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b f1=%0d f2=%0d lf=%b sbe=%b sc=%0d, want ctl=%b f1=%0d f2=%0d lf=%b sbe=%b sc=%0d",
                   e.name, ctl, forward_rs1, forward_rs2, long_full, sb_error, stall_count,
                   e.ctl, e.f1, e.f2, e.lf, e.sbe, e.sc);
        end
      end
    end
  end

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    expect_o("reset", NORM, 0, 0, 0, 0, 0);
    nxt(); reset = 0;

    // Forwarding
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; stage_write_reg = 3'b001; stage_rd = {5'd0, 5'd0, 5'd5};
    expect_o("fwd_s1", NORM, 1, 0, 0, 0, 0);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1 = 5; id_rs2 = 5;
    stage_write_reg = 3'b011; stage_rd = {5'd0, 5'd5, 5'd5};
    expect_o("fwd_s1_over_s2", NORM, 1, 1, 0, 0, 0);
    nxt();
    id_valid = 1; id_uses_rs2 = 1; id_rs1 = 6; id_rs2 = 6;
    stage_write_reg = 3'b110; stage_rd = {5'd6, 5'd6, 5'd0};
    expect_o("fwd_s2_rs1_unused", NORM, 0, 2, 0, 0, 0);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 0; stage_write_reg = 3'b001; stage_not_ready = 3'b001;
    expect_o("x0_no_fwd", NORM, 0, 0, 0, 0, 0);
    nxt();
    // Load-use
    id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; stage_write_reg = 3'b001;
    stage_rd = {5'd0, 5'd0, 5'd7}; stage_not_ready = 3'b001;
    expect_o("load_use", STALL, 0, 0, 0, 0, 0);
    nxt();
    id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; stage_write_reg = 3'b010; stage_rd = {5'd0, 5'd7, 5'd0};
    expect_o("load_use_after", NORM, 0, 2, 0, 0, 1);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 7; stage_write_reg = 3'b011;
    stage_rd = {5'd0, 5'd7, 5'd7}; stage_not_ready = 3'b010;
    expect_o("lowest_ready", NORM, 1, 0, 0, 0, 1);
    nxt();

    // Long-latency scoreboard
    for (int i = 1; i <= 4; i++) begin
      long_issue(5'(i));
      expect_o($sformatf("long_issue_%0d", i), NORM, 0, 0, 0, 0, 1);
      nxt();
    end
    long_issue(5);
    expect_o("long_full_stall", STALL, 0, 0, 1, 0, 1);
    nxt();
    long_issue(5); long_done = 1; long_done_rd = 2;
    expect_o("long_issue_with_done", NORM, 0, 0, 1, 0, 2);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3;
    expect_o("raw_busy", STALL, 0, 0, 1, 0, 2);
    nxt();
    id_valid = 1; id_write_reg = 1; id_rd = 4;
    expect_o("waw_busy", STALL, 0, 0, 1, 0, 3);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 2;
    expect_o("x2_cleared", NORM, 0, 0, 1, 0, 4);
    nxt();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; dmem_wait = 1;
    expect_o("dmem_wait_stall", 5'b00010, 0, 0, 1, 0, 4);
    nxt();
    imem_wait = 1; long_done = 1; long_done_rd = 1;
    expect_o("done_while_held", 5'b01100, 0, 0, 1, 0, 4);
    nxt();
    expect_o("not_full", NORM, 0, 0, 0, 0, 4);
    nxt();
    for (int i = 3; i <= 5; i++) begin
      long_done = 1; long_done_rd = 5'(i);
      expect_o($sformatf("drain_%0d", i), NORM, 0, 0, 0, 0, 4);
      nxt();
    end
    long_done = 1; long_done_rd = 9;
    expect_o("done_at_zero", NORM, 0, 0, 0, 0, 4);
    nxt();
    expect_o("sb_error_set", NORM, 0, 0, 0, 1, 4);
    nxt();
    expect_o("sb_error_sticky", NORM, 0, 0, 0, 1, 4);
    nxt();

    // Branch: taken
    id_valid = 1; id_is_branch = 1;
    expect_o("br_issue", NORM, 0, 0, 0, 1, 4);
    nxt();
    expect_o("br_wait", STALL, 0, 0, 0, 1, 4);
    nxt();
    br_resolve = 1; br_taken = 1;
    expect_o("br_resolve_taken", WRES, 0, 0, 0, 1, 5);
    nxt();
    expect_o("br_flush", FLUSH, 0, 0, 0, 1, 6);
    nxt();
    br_resolve = 1; br_taken = 1;
    expect_o("br_idle_ignore", NORM, 0, 0, 0, 1, 7);
    nxt();
    expect_o("br_still_idle", NORM, 0, 0, 0, 1, 7);
    nxt();
    // Branch: not taken
    id_valid = 1; id_is_branch = 1;
    expect_o("br2_issue", NORM, 0, 0, 0, 1, 7);
    nxt();
    br_resolve = 1;
    expect_o("br2_resolve_nt", WRES, 0, 0, 0, 1, 7);
    nxt();
    expect_o("br2_idle", NORM, 0, 0, 0, 1, 8);
    nxt();

    // Reset clears sticky error and counter, overriding same-cycle activity
    reset = 1; long_done = 1; long_done_rd = 3; long_issue(6);
    expect_o("reset_cycle", NORM, 0, 0, 0, 1, 8);
    nxt(); reset = 0;
    expect_o("after_reset", NORM, 0, 0, 0, 0, 0);
    nxt();
    expect_o("after_reset_idle", NORM, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
